// File: rtl/alt_link_pkg.sv
// Shared types for the alternating dual-lane link receiver.
package alt_link_pkg;

  localparam int unsigned LANE_W = 8;

  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic {
    IDLE,
    TRACK
  } rx_state_t;

endpackage

// File: rtl/alt_seq_checker.sv
// Holds the reference sample and elapsed-cycle count; flags counter-progression
// violations when a fresh sample arrives while tracking.
module alt_seq_checker
  import alt_link_pkg::*;
#(
  parameter int unsigned WIDTH = LANE_W,
  parameter int unsigned GAP_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fresh,
  input  logic             track,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             seq_hit
);

  localparam logic [GAP_W-1:0] GAP_MAX = '1;
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  logic [WIDTH-1:0] ref_a;
  logic [WIDTH-1:0] ref_b;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] exp_a;
  logic [WIDTH-1:0] exp_b;
  logic [GAP_W-1:0] elapsed;

  // A saturated gap means the true distance is unknown, so no check is made.
  always_comb begin
    step    = WIDTH'(elapsed);
    exp_a   = ref_a - step;
    exp_b   = ref_b + step;
    seq_hit = fresh && track && (elapsed != GAP_MAX) &&
              ((in_a != exp_a) || (in_b != exp_b));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ref_a   <= '0;
      ref_b   <= '0;
      elapsed <= '0;
    end else if (fresh) begin
      ref_a   <= in_a;
      ref_b   <= in_b;
      elapsed <= GAP_ONE;
    end else if (track && (elapsed != GAP_MAX)) begin
      elapsed <= elapsed + GAP_ONE;
    end
  end

endmodule

// File: rtl/alternating_receiver.sv
// Receiver for the alternating dual-counter link: un-swaps lanes, checks the
// per-cycle lane exchange and the counter progression between fresh samples.
// Optional error counter output enabled by defining ALT_RX_ERR_COUNT_EN.
module alternating_receiver
  import alt_link_pkg::*;
#(
  parameter int unsigned WIDTH = LANE_W,
  parameter int unsigned GAP_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fresh,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] dec_a,
  output logic [WIDTH-1:0] dec_b,
  output logic             dec_valid,
  output logic             locked,
  output logic             swap_err,
  output logic             seq_err
`ifdef ALT_RX_ERR_COUNT_EN
  ,
  output logic [15:0]      err_count
`endif
);

  rx_state_t        state;
  rx_state_t        state_nx;
  logic             track;
  logic             phase;
  logic             phase_nx;
  logic [WIDTH-1:0] prev_a;
  logic [WIDTH-1:0] prev_b;
  logic [WIDTH-1:0] dec_a_nx;
  logic [WIDTH-1:0] dec_b_nx;
  logic             dec_valid_nx;
  logic             swap_err_nx;
  logic             seq_hit;

  assign track  = (state == TRACK);
  assign locked = track;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (fresh) state_nx = TRACK;
  end

  // Phase describes the current input; fresh forces the straight lane order.
  always_comb begin
    phase_nx     = phase;
    dec_a_nx     = dec_a;
    dec_b_nx     = dec_b;
    dec_valid_nx = 1'b0;
    swap_err_nx  = 1'b0;
    if (fresh) begin
      phase_nx     = 1'b0;
      dec_a_nx     = in_a;
      dec_b_nx     = in_b;
      dec_valid_nx = 1'b1;
    end else if (track) begin
      phase_nx     = ~phase;
      dec_valid_nx = 1'b1;
      swap_err_nx  = (in_a != prev_b) || (in_b != prev_a);
      if (phase_nx) begin
        dec_a_nx = in_b;
        dec_b_nx = in_a;
      end else begin
        dec_a_nx = in_a;
        dec_b_nx = in_b;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase     <= 1'b0;
      prev_a    <= '0;
      prev_b    <= '0;
      dec_a     <= '0;
      dec_b     <= '0;
      dec_valid <= 1'b0;
      swap_err  <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      phase     <= phase_nx;
      prev_a    <= in_a;
      prev_b    <= in_b;
      dec_a     <= dec_a_nx;
      dec_b     <= dec_b_nx;
      dec_valid <= dec_valid_nx;
      swap_err  <= swap_err_nx;
      seq_err   <= seq_hit;
    end
  end

  alt_seq_checker #(
    .WIDTH (WIDTH),
    .GAP_W (GAP_W)
  ) u_seq_checker (
    .clock   (clock),
    .reset   (reset),
    .fresh   (fresh),
    .track   (track),
    .in_a    (in_a),
    .in_b    (in_b),
    .seq_hit (seq_hit)
  );

`ifdef ALT_RX_ERR_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      err_count <= '0;
    end else if ((swap_err_nx || seq_hit) && (err_count != '1)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alternating_receiver.sv
// Bench for alternating_receiver: directed protocol cases plus randomized
// source traffic compared every cycle against a cycle-count based model.
module tb_alternating_receiver;

  localparam int unsigned W   = 8;
  localparam int unsigned GW  = 16;
  localparam int          SAT = (1 << GW) - 1;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         fresh = 1'b0;
  logic [W-1:0] in_a  = '0;
  logic [W-1:0] in_b  = '0;
  logic [W-1:0] dec_a;
  logic [W-1:0] dec_b;
  logic         dec_valid;
  logic         locked;
  logic         swap_err;
  logic         seq_err;
`ifdef ALT_RX_ERR_COUNT_EN
  logic [15:0]  err_count;
`endif

  int checks = 0;
  int errors = 0;

  alternating_receiver #(
    .WIDTH (W),
    .GAP_W (GW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .fresh     (fresh),
    .in_a      (in_a),
    .in_b      (in_b),
    .dec_a     (dec_a),
    .dec_b     (dec_b),
    .dec_valid (dec_valid),
    .locked    (locked),
    .swap_err  (swap_err),
    .seq_err   (seq_err)
`ifdef ALT_RX_ERR_COUNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: protocol rules expressed via absolute cycle numbers.
  bit           m_started = 0;
  bit           m_track   = 0;
  int           m_cyc     = 0;
  int           m_last    = 0;
  logic [W-1:0] m_ref_a   = '0;
  logic [W-1:0] m_ref_b   = '0;
  logic [W-1:0] m_prev_a  = '0;
  logic [W-1:0] m_prev_b  = '0;
  logic [W-1:0] e_dec_a   = '0;
  logic [W-1:0] e_dec_b   = '0;
  logic         e_valid   = 0;
  logic         e_swap    = 0;
  logic         e_seq     = 0;
  int           e_cnt     = 0;

  initial forever begin
    int k;
    logic [W-1:0] ka;
    @(posedge clock);
    if (reset) begin
      m_started = 1;
      m_track = 0; m_last = m_cyc;
      m_ref_a = '0; m_ref_b = '0; m_prev_a = '0; m_prev_b = '0;
      e_dec_a = '0; e_dec_b = '0; e_valid = 0; e_swap = 0; e_seq = 0; e_cnt = 0;
    end else begin
      k = m_cyc - m_last;
      e_valid = 0; e_swap = 0; e_seq = 0;
      if (fresh) begin
        if (m_track && k < SAT) begin
          ka = W'(k);
          e_seq = (in_a != W'(m_ref_a - ka)) || (in_b != W'(m_ref_b + ka));
        end
        m_ref_a = in_a; m_ref_b = in_b; m_last = m_cyc; m_track = 1;
        e_valid = 1; e_dec_a = in_a; e_dec_b = in_b;
      end else if (m_track) begin
        e_valid = 1;
        e_swap = (in_a != m_prev_b) || (in_b != m_prev_a);
        if (k % 2 == 1) begin e_dec_a = in_b; e_dec_b = in_a; end
        else            begin e_dec_a = in_a; e_dec_b = in_b; end
      end
      if ((e_swap || e_seq) && e_cnt < 65535) e_cnt++;
      m_prev_a = in_a; m_prev_b = in_b;
    end
    m_cyc++;
  end

  initial forever begin
    @(negedge clock);
    if (m_started) begin
      chk("m_valid",  dec_valid, e_valid);
      chk("m_locked", locked,    m_track);
      chk("m_dec_a",  dec_a,     e_dec_a);
      chk("m_dec_b",  dec_b,     e_dec_b);
      chk("m_swap",   swap_err,  e_swap);
      chk("m_seq",    seq_err,   e_seq);
`ifdef ALT_RX_ERR_COUNT_EN
      chk("m_count",  err_count, e_cnt);
`endif
    end
  end

  // Apply inputs, then return just after the edge that consumed them.
  task automatic cyc(input logic f, input logic [W-1:0] a, input logic [W-1:0] b);
    fresh = f; in_a = a; in_b = b;
    @(posedge clock);
    #1;
  endtask

  // Non-fresh cycles i=from..to after a fresh of (a,b): odd cycles swapped.
  task automatic run_alt(input logic [W-1:0] a, input logic [W-1:0] b, input int from, input int to);
    for (int i = from; i <= to; i++) begin
      if (i % 2 == 1) cyc(0, b, a);
      else            cyc(0, a, b);
    end
  endtask

  initial begin
    logic [W-1:0] src_a, src_b, la, lb, ph_a, ph_b;
    int since;

    reset = 1;
    cyc(0, 8'h00, 8'h00);
    cyc(0, 8'h00, 8'h00);
    chk("rst_valid", dec_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_dec_a", dec_a, 0);
    chk("rst_errs", {swap_err, seq_err}, 0);
    reset = 0;

    cyc(1, 8'hFB, 8'h85);
    chk("first_dec", {dec_a, dec_b}, 16'hFB85);
    chk("first_valid_locked", {dec_valid, locked}, 2'b11);
    chk("first_errs", {swap_err, seq_err}, 0);
    cyc(0, 8'h85, 8'hFB);
    chk("unswap1", {dec_a, dec_b, swap_err}, {16'hFB85, 1'b0});
    cyc(0, 8'hFB, 8'h85);
    chk("unswap2", {dec_a, dec_b, swap_err}, {16'hFB85, 1'b0});
    run_alt(8'hFB, 8'h85, 3, 9);
    cyc(1, 8'hF1, 8'h8F);
    chk("seq_good10", seq_err, 0);
    run_alt(8'hF1, 8'h8F, 1, 9);
    cyc(1, 8'hF2, 8'h8F);
    chk("seq_bad10", seq_err, 1);
    run_alt(8'hF2, 8'h8F, 1, 1);
    chk("seq_pulse_end", seq_err, 0);

    cyc(1, 8'h02, 8'hFE);
    run_alt(8'h02, 8'hFE, 1, 4);
    cyc(1, 8'hFD, 8'h03);
    chk("seq_wrap", seq_err, 0);

    reset = 1; cyc(0, 8'h00, 8'h00); reset = 0;
    cyc(1, 8'hFB, 8'h85);
`ifdef ALT_RX_ERR_COUNT_EN
    chk("cnt_before", err_count, 0);
`endif
    cyc(0, 8'h85, 8'h85);
    chk("swap_bad", swap_err, 1);
`ifdef ALT_RX_ERR_COUNT_EN
    chk("cnt_after", err_count, 1);
`endif
    cyc(0, 8'h85, 8'h85);
    chk("swap_pulse_end", swap_err, 0);

    reset = 1; cyc(0, 8'h00, 8'h00); reset = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, W'($urandom), W'($urandom));
      chk("idle_quiet", {dec_valid, locked, swap_err, seq_err}, 0);
    end
    cyc(1, 8'h11, 8'h22);
    cyc(0, 8'h22, 8'h11);
    reset = 1;
    cyc(0, 8'h11, 8'h22);
    chk("midrst_out", {dec_valid, locked, swap_err, seq_err, dec_a, dec_b}, 0);
    reset = 0;
    cyc(1, 8'h00, 8'h80);
    chk("relock", {locked, dec_valid, seq_err}, 3'b110);

    run_alt(8'h00, 8'h80, 1, 1 << GW);
    cyc(1, 8'h55, 8'h66);
    chk("gap_sat", seq_err, 0);
    run_alt(8'h55, 8'h66, 1, 2);
    cyc(1, 8'h52, 8'h69);
    chk("gap_new_ref", seq_err, 0);
    run_alt(8'h52, 8'h69, 1, 1);
    cyc(1, 8'h00, 8'h00);
    chk("gap_ref_bad", seq_err, 1);

    // Randomized source: live counters latched on fresh, lanes swapped between.
    src_a = W'($urandom); src_b = W'($urandom); la = src_a; lb = src_b; since = 0;
    for (int n = 0; n < 3000; n++) begin
      src_a = src_a - 1'b1; src_b = src_b + 1'b1; since++;
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 6) == 0) begin
        if ($urandom_range(0, 4) == 0) begin src_a = W'($urandom); src_b = W'($urandom); end
        la = src_a; lb = src_b; since = 0;
        ph_a = la; ph_b = lb;
        if ($urandom_range(0, 39) == 0) ph_b = ph_b ^ W'($urandom_range(1, 255));
        cyc(1, ph_a, ph_b);
      end else begin
        if (since % 2 == 1) begin ph_a = lb; ph_b = la; end
        else                begin ph_a = la; ph_b = lb; end
        if ($urandom_range(0, 19) == 0) ph_a = ph_a ^ W'($urandom_range(1, 255));
        cyc(0, ph_a, ph_b);
      end
    end
    reset = 0;
    cyc(0, 8'h00, 8'h00);
    @(posedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
